// File: rtl/apb_master_bridge_n_if.sv
// APB bus bundle between the bridge (master) and its slaves.
interface apb_master_bridge_n_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 9,
  parameter int NUM_SLV = 2
);
  logic [NUM_SLV-1:0]        psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [NUM_SLV*DATA_W-1:0] prdata;
  logic [NUM_SLV-1:0]        pready;
  logic [NUM_SLV-1:0]        pslverr;

  modport master (output psel, penable, pwrite, paddr, pwdata,
                  input  prdata, pready, pslverr);
  modport slave  (input  psel, penable, pwrite, paddr, pwdata,
                  output prdata, pready, pslverr);
endinterface

// File: rtl/apb_master_bridge_n.sv
// Command-to-APB master bridge: IDLE/SETUP/ACCESS with per-slave decode,
// back-to-back commands, slave error reporting and an ACCESS timeout.
module apb_master_bridge_n #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 9,
  parameter int NUM_SLV = 2,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              transfer,
  input  logic              read_write,
  input  logic [ADDR_W-1:0] apb_write_paddr,
  input  logic [ADDR_W-1:0] apb_read_paddr,
  input  logic [DATA_W-1:0] apb_write_data,
  output logic [DATA_W-1:0] apb_read_data_out,
  output logic              busy,
  output logic              xfer_done,
  output logic              xfer_err,
  apb_master_bridge_n_if.master apb
);
  localparam int SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic              pwrite_q;
  logic [CNT_W-1:0]  wait_cnt_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done_q, err_q;

  logic [ADDR_W-1:0] nxt_addr;
  logic [SEL_W-1:0]  nxt_idx, cmd_idx;
  logic              nxt_ok;
  logic              rdy_s, slverr_s;
  logic [DATA_W-1:0] rdat_s;
  logic [NUM_SLV-1:0] psel_dec;
  logic              load, done_d, err_d, rd_ld, cnt_clr, cnt_inc;

  assign nxt_addr = read_write ? apb_read_paddr : apb_write_paddr;
  assign nxt_idx  = nxt_addr[ADDR_W-1 -: SEL_W];
  assign nxt_ok   = int'(nxt_idx) < NUM_SLV;
  assign cmd_idx  = cmd_addr_q[ADDR_W-1 -: SEL_W];

  // Only the addressed slave's response is visible to the FSM.
  always_comb begin
    rdy_s    = 1'b0;
    slverr_s = 1'b0;
    rdat_s   = '0;
    psel_dec = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (cmd_idx == SEL_W'(i)) begin
        rdy_s       = apb.pready[i];
        slverr_s    = apb.pslverr[i];
        rdat_s      = apb.prdata[i*DATA_W +: DATA_W];
        psel_dec[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rd_ld   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: if (transfer) begin
        // Out-of-range slave index is rejected without any bus cycle.
        if (nxt_ok) begin
          load    = 1'b1;
          state_d = SETUP;
        end else begin
          err_d = 1'b1;
        end
      end
      SETUP: begin
        cnt_clr = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (rdy_s) begin
          done_d = 1'b1;
          err_d  = slverr_s;
          rd_ld  = !pwrite_q && !slverr_s;
          // A bad next index falls back to IDLE, which then reports it.
          if (transfer && nxt_ok) begin
            load    = 1'b1;
            state_d = SETUP;
          end else begin
            state_d = IDLE;
          end
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      pwrite_q    <= 1'b0;
      wait_cnt_q  <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      if (load) begin
        cmd_addr_q  <= nxt_addr;
        cmd_wdata_q <= apb_write_data;
        pwrite_q    <= !read_write;
      end
      if (cnt_clr)      wait_cnt_q <= '0;
      else if (cnt_inc) wait_cnt_q <= wait_cnt_q + 1'b1;
      if (rd_ld) rdata_q <= rdat_s;
    end
  end

  assign apb.psel           = (state_q != IDLE) ? psel_dec : '0;
  assign apb.penable        = (state_q == ACCESS);
  assign apb.pwrite         = pwrite_q;
  assign apb.paddr          = cmd_addr_q;
  assign apb.pwdata         = cmd_wdata_q;
  assign apb_read_data_out  = rdata_q;
  assign busy               = (state_q != IDLE);
  assign xfer_done          = done_q;
  assign xfer_err           = err_q;
endmodule

// File: tb/tb_apb_master_bridge_n.sv
// Directed bench for apb_master_bridge_n: write, waited read, slave error,
// timeout, back-to-back, out-of-range slave and mid-ACCESS reset.
module tb_apb_master_bridge_n;
  logic       pclk = 1'b0;
  logic       presetn = 1'b1;
  logic       transfer, transfer1, read_write;
  logic [8:0] wr_addr, rd_addr;
  logic [7:0] wdata;
  logic [7:0] rdata0, rdata1;
  logic       busy0, done0, err0, busy1, done1, err1;

  int checks = 0;
  int failures = 0;

  apb_master_bridge_n_if #(.DATA_W(8), .ADDR_W(9), .NUM_SLV(2)) bus0 ();
  apb_master_bridge_n_if #(.DATA_W(8), .ADDR_W(9), .NUM_SLV(3)) bus1 ();

  apb_master_bridge_n #(.DATA_W(8), .ADDR_W(9), .NUM_SLV(2), .TIMEOUT(16)) dut (
    .pclk(pclk), .presetn(presetn), .transfer(transfer), .read_write(read_write),
    .apb_write_paddr(wr_addr), .apb_read_paddr(rd_addr), .apb_write_data(wdata),
    .apb_read_data_out(rdata0), .busy(busy0), .xfer_done(done0), .xfer_err(err0),
    .apb(bus0));

  apb_master_bridge_n #(.DATA_W(8), .ADDR_W(9), .NUM_SLV(3), .TIMEOUT(16)) dut3 (
    .pclk(pclk), .presetn(presetn), .transfer(transfer1), .read_write(read_write),
    .apb_write_paddr(wr_addr), .apb_read_paddr(rd_addr), .apb_write_data(wdata),
    .apb_read_data_out(rdata1), .busy(busy1), .xfer_done(done1), .xfer_err(err1),
    .apb(bus1));

  always #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  initial begin
    transfer = 0; transfer1 = 0; read_write = 0;
    wr_addr = '0; rd_addr = '0; wdata = '0;
    bus0.prdata = '0; bus0.pready = '0; bus0.pslverr = '0;
    bus1.prdata = '0; bus1.pready = '0; bus1.pslverr = '0;

    // reset values
    #2 presetn = 0;
    #1;
    chk("rst_psel", 32'(bus0.psel), 0);
    chk("rst_ctl", {bus0.penable, bus0.pwrite, busy0, done0, err0}, 0);
    chk("rst_data", {bus0.paddr, bus0.pwdata, rdata0}, 0);
    repeat (2) @(posedge pclk);
    #2 presetn = 1;
    tick();

    // write, slave 0, zero wait
    transfer = 1; read_write = 0; wr_addr = 9'h005; wdata = 8'hA5; bus0.pready = 2'b01;
    tick();
    transfer = 0;
    chk("wr_setup_psel", 32'(bus0.psel), 32'h1);
    chk("wr_setup_ctl", {bus0.penable, bus0.pwrite, busy0}, 3'b011);
    chk("wr_setup_bus", {bus0.paddr, bus0.pwdata}, {9'h005, 8'hA5});
    tick();
    chk("wr_access", {30'(bus0.psel), bus0.penable, done0}, {30'h1, 1'b1, 1'b0});
    tick();
    chk("wr_done", {done0, err0, busy0, 2'(bus0.psel)}, 5'b10000);
    tick();
    chk("wr_done_pulse", 32'(done0), 0);

    // read, slave 1, two wait cycles; slave 0 ready is ignored
    transfer = 1; read_write = 1; rd_addr = 9'h10C;
    bus0.prdata = {8'h3C, 8'h99}; bus0.pready = 2'b01;
    tick();
    transfer = 0;
    chk("rd_setup", {30'(bus0.psel), bus0.penable, bus0.pwrite}, {30'h2, 2'b00});
    chk("rd_addr", 32'(bus0.paddr), 32'h10C);
    tick();
    tick();
    chk("rd_wait2", {bus0.penable, done0, busy0}, 3'b101);
    bus0.pready = 2'b10;
    tick();
    chk("rd_done", {done0, err0}, 2'b10);
    chk("rd_data", 32'(rdata0), 32'h3C);

    // read, slave 0 signals slverr
    transfer = 1; rd_addr = 9'h020; bus0.prdata = {8'h00, 8'h77};
    bus0.pready = 2'b01; bus0.pslverr = 2'b01;
    tick();
    transfer = 0;
    tick();
    tick();
    chk("err_flags", {done0, err0}, 2'b11);
    chk("err_rdata_kept", 32'(rdata0), 32'h3C);
    bus0.pslverr = '0;

    // timeout: slave 0 never ready
    transfer = 1; read_write = 0; wr_addr = 9'h001; bus0.pready = 2'b00;
    tick();
    transfer = 0;
    for (int i = 0; i < 16; i++) tick();
    chk("to_last_access", {bus0.penable, busy0, err0}, 3'b110);
    tick();
    chk("to_abort", {done0, err0, busy0, bus0.penable, 2'(bus0.psel)}, 6'b010000);

    // back-to-back writes with transfer held high
    transfer = 1; wdata = 8'h11; bus0.pready = 2'b01;
    tick();
    wdata = 8'h22;
    tick();
    tick();
    chk("b2b_1", {done0, busy0, bus0.penable, bus0.pwdata}, {3'b110, 8'h22});
    wdata = 8'h33;
    tick();
    chk("b2b_gap", {done0, bus0.penable}, 2'b01);
    tick();
    chk("b2b_2", {done0, busy0, bus0.penable, bus0.pwdata}, {3'b110, 8'h33});
    transfer = 0;
    tick();
    tick();
    chk("b2b_3", {done0, busy0}, 2'b10);

    // NUM_SLV=3: index 3 rejected, index 2 serviced
    transfer1 = 1; read_write = 0; wr_addr = 9'h180;
    tick();
    transfer1 = 0;
    chk("bad_idx", {err1, done1, busy1, 3'(bus1.psel)}, 6'b100000);
    tick();
    chk("bad_idx_pulse", {err1, busy1}, 2'b00);
    transfer1 = 1; wr_addr = 9'h100; bus1.pready = 3'b100;
    tick();
    transfer1 = 0;
    chk("idx2_psel", 32'(bus1.psel), 32'h4);
    tick();
    tick();
    chk("idx2_done", {done1, err1}, 2'b10);

    // reset in the middle of ACCESS
    transfer = 1; wr_addr = 9'h0AB; wdata = 8'h5A; bus0.pready = 2'b00;
    tick();
    transfer = 0;
    tick();
    chk("pre_rst_access", 32'(bus0.penable), 1);
    #2 presetn = 0;
    #1;
    chk("mid_rst_ctl", {2'(bus0.psel), bus0.penable, bus0.pwrite, busy0, done0, err0}, 0);
    chk("mid_rst_data", {bus0.paddr, bus0.pwdata, rdata0}, 0);
    #1 presetn = 1;
    tick();
    chk("post_rst_idle", {busy0, done0, err0}, 3'b000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
